// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for the iterative InvMixColumns unit: input state channel and result channel.
interface inv_mix_columns_iter_if;
  localparam int unsigned STATE_W = 128;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] ostate;

  modport master (output in_valid, state, out_ready,
                  input  in_ready, out_valid, ostate);
  modport slave  (input  in_valid, state, out_ready,
                  output in_ready, out_valid, ostate);
endinterface

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: transforms COLS_PER_CYCLE columns per clock, starting at the top column,
// then holds the result until the consumer accepts it.
module inv_mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  inv_mix_columns_iter_if.slave bus
);
  localparam int unsigned NCOLS   = 4;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned STATE_W = NCOLS * COL_W;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the inverse-matrix constants 09/0b/0d/0e.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      8'h09:   return x8 ^ x;
      8'h0b:   return x8 ^ x2 ^ x;
      8'h0d:   return x8 ^ x4 ^ x;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  function automatic logic [COL_W-1:0] inv_col(input logic [COL_W-1:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
            gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
            gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
            gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [STATE_W-1:0] ostate_q, ostate_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               last_grp_c;
  logic [1:0]         col_idx;

  assign last_grp_c = (cnt_q + CNT_W'(COLS_PER_CYCLE)) == CNT_W'(NCOLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_grp_c)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; flags follow the state being entered.
  always_comb begin
    cnt_d       = cnt_q;
    work_d      = work_q;
    ostate_d    = ostate_q;
    col_idx     = '0;
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.state;
          cnt_d  = '0;
        end
      end
      BUSY: begin
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          col_idx = 2'(CNT_W'(NCOLS - 1) - cnt_q - CNT_W'(j));
          work_d[col_idx*COL_W +: COL_W] = inv_col(work_q[col_idx*COL_W +: COL_W]);
        end
        cnt_d = cnt_q + CNT_W'(COLS_PER_CYCLE);
        if (last_grp_c) ostate_d = work_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      work_q      <= '0;
      ostate_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      ostate_q    <= ostate_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ostate    = ostate_q;
endmodule
